// File: rtl/rr_select_arbiter8.sv
// Round-robin arbiter driving the select of an 8-to-1 data multiplexer.
// In packet mode a grant is held until a last beat is transferred.
module rr_select_arbiter8 #(
  parameter bit PacketMode = 1'b1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] reqValid,
  input  logic [7:0] reqLast,
  output logic [7:0] reqReady,
  output logic [2:0] select,
  output logic       outValid,
  output logic       outLast,
  input  logic       outReady,
  output logic       busy
);

  localparam int unsigned NumReq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   select_q, select_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic              busy_q, busy_d;

  logic [IdxW-1:0]   search_start;
  logic [IdxW-1:0]   winner;
  logic              any_valid;
  logic              xfer;
  logic              release_beat;

  // First valid index scanning start, start+1, ... with mod-8 wrap.
  function automatic logic [IdxW-1:0] find_winner(input logic [NumReq-1:0] valid,
                                                  input logic [IdxW-1:0]   start);
    logic [IdxW-1:0] idx;
    logic [IdxW-1:0] result;
    logic            found;
    result = start;
    found  = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = start + IdxW'(k);
      if (!found && valid[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  // Search restarts just after the current grant on release, otherwise at ptr.
  assign search_start = (state_q == GRANT) ? (select_q + IdxW'(1)) : ptr_q;
  assign winner       = find_winner(reqValid, search_start);
  assign any_valid    = |reqValid;

  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    ptr_d        = ptr_q;
    busy_d       = busy_q;
    outValid     = 1'b0;
    outLast      = 1'b0;
    reqReady     = '0;
    xfer         = 1'b0;
    release_beat = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          select_d = winner;
          state_d  = GRANT;
          busy_d   = 1'b1;
        end
      end
      GRANT: begin
        outValid           = reqValid[select_q];
        outLast            = reqLast[select_q];
        reqReady[select_q] = outReady;
        xfer               = outValid && outReady;
        release_beat       = xfer && (PacketMode ? outLast : 1'b1);
        if (release_beat) begin
          ptr_d = select_q + IdxW'(1);
          if (any_valid) begin
            select_d = winner;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      select_q <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign select = select_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rr_select_arbiter8.sv
// Directed bench for rr_select_arbiter8: one beat-mode and one packet-mode
// instance share stimulus; each scenario task checks the relevant instance.
module tb_rr_select_arbiter8;

  logic       clk;
  logic       rstN;
  logic [7:0] reqValid;
  logic [7:0] reqLast;
  logic       outReady;

  logic [7:0] b_ready;
  logic [2:0] b_sel;
  logic       b_ov, b_ol, b_busy;
  logic [7:0] p_ready;
  logic [2:0] p_sel;
  logic       p_ov, p_ol, p_busy;

  int n_pass;
  int n_total;

  rr_select_arbiter8 #(.PacketMode(1'b0)) u_beat (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqLast(reqLast),
    .reqReady(b_ready), .select(b_sel), .outValid(b_ov), .outLast(b_ol),
    .outReady(outReady), .busy(b_busy)
  );

  rr_select_arbiter8 #(.PacketMode(1'b1)) u_pkt (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqLast(reqLast),
    .reqReady(p_ready), .select(p_sel), .outValid(p_ov), .outLast(p_ol),
    .outReady(outReady), .busy(p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rstN     = 1'b0;
    reqValid = 8'h00;
    reqLast  = 8'h00;
    outReady = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      n_total++;
      if ({p_sel, p_ov, p_ready, p_busy} !== 13'h0) begin
        $display("FAIL reset_idle_pkt cycle %0d: got sel=%0d ov=%b rdy=%h busy=%b, expected all 0",
                 c, p_sel, p_ov, p_ready, p_busy);
      end else n_pass++;
      n_total++;
      if ({b_sel, b_ov, b_ready, b_busy} !== 13'h0) begin
        $display("FAIL reset_idle_beat cycle %0d: got sel=%0d ov=%b rdy=%h busy=%b, expected all 0",
                 c, b_sel, b_ov, b_ready, b_busy);
      end else n_pass++;
    end
  endtask

  task automatic test_beat_rotation();
    logic [7:0] exp_rdy;
    apply_reset();
    reqValid = 8'hFF;
    outReady = 1'b1;
    #1;
    n_total++;
    if ({b_ov, b_busy} !== 2'b00) begin
      $display("FAIL rot_latency: got ov=%b busy=%b, expected 0 0", b_ov, b_busy);
    end else n_pass++;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      #1;
      exp_rdy = 8'h01 << (k % 8);
      n_total++;
      if (b_sel !== 3'(k % 8) || b_ready !== exp_rdy || b_ov !== 1'b1 || b_busy !== 1'b1) begin
        $display("FAIL rot_beat %0d: got sel=%0d rdy=%h ov=%b busy=%b, expected sel=%0d rdy=%h ov=1 busy=1",
                 k, b_sel, b_ready, b_ov, b_busy, k % 8, exp_rdy);
      end else n_pass++;
    end
  endtask

  task automatic test_packet_hold();
    apply_reset();
    reqValid = 8'h24;
    reqLast  = 8'h00;
    outReady = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      reqLast = (b == 2) ? 8'h04 : 8'h00;
      #1;
      n_total++;
      if (p_sel !== 3'd2 || p_ready !== 8'h04 || p_ol !== (b == 2)) begin
        $display("FAIL pkt_beat %0d: got sel=%0d rdy=%h last=%b, expected sel=2 rdy=04 last=%0d",
                 b, p_sel, p_ready, p_ol, (b == 2));
      end else n_pass++;
    end
    @(negedge clk);
    reqValid = 8'h20;
    reqLast  = 8'h00;
    #1;
    n_total++;
    if (p_sel !== 3'd5 || p_ready !== 8'h20 || p_ov !== 1'b1) begin
      $display("FAIL pkt_next: got sel=%0d rdy=%h ov=%b, expected sel=5 rdy=20 ov=1",
               p_sel, p_ready, p_ov);
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    int xfers;
    apply_reset();
    reqValid = 8'h08;
    outReady = 1'b0;
    xfers    = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      outReady = (c % 2) == 1;
      #1;
      if (p_ov && outReady) xfers++;
      n_total++;
      if (p_sel !== 3'd3 || p_ready !== (outReady ? 8'h08 : 8'h00)) begin
        $display("FAIL bp_cycle %0d: got sel=%0d rdy=%h, expected sel=3 rdy=%h",
                 c, p_sel, p_ready, outReady ? 8'h08 : 8'h00);
      end else n_pass++;
    end
    n_total++;
    if (xfers !== 4) begin
      $display("FAIL bp_count: got %0d transfers, expected 4", xfers);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    reqValid = 8'h80;
    outReady = 1'b0;
    @(negedge clk);
    outReady = 1'b1;
    reqValid = 8'h81;
    #1;
    n_total++;
    if (b_sel !== 3'd7 || b_ready !== 8'h80) begin
      $display("FAIL wrap_first: got sel=%0d rdy=%h, expected sel=7 rdy=80", b_sel, b_ready);
    end else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (b_sel !== 3'd0 || b_ready !== 8'h01) begin
      $display("FAIL wrap_to0: got sel=%0d rdy=%h, expected sel=0 rdy=01", b_sel, b_ready);
    end else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (b_sel !== 3'd7 || b_ready !== 8'h80) begin
      $display("FAIL wrap_back7: got sel=%0d rdy=%h, expected sel=7 rdy=80", b_sel, b_ready);
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    reqValid = 8'h10;
    reqLast  = 8'h00;
    outReady = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (p_sel !== 3'd4 || p_ready !== 8'h10) begin
      $display("FAIL arst_beat1: got sel=%0d rdy=%h, expected sel=4 rdy=10", p_sel, p_ready);
    end else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (p_sel !== 3'd4 || p_ov !== 1'b1 || p_busy !== 1'b1) begin
      $display("FAIL arst_beat2: got sel=%0d ov=%b busy=%b, expected sel=4 ov=1 busy=1",
               p_sel, p_ov, p_busy);
    end else n_pass++;
    #2;
    rstN = 1'b0;
    #1;
    n_total++;
    if ({p_sel, p_ov, p_ol, p_ready, p_busy} !== 14'h0) begin
      $display("FAIL arst_immediate: got sel=%0d ov=%b last=%b rdy=%h busy=%b, expected all 0",
               p_sel, p_ov, p_ol, p_ready, p_busy);
    end else n_pass++;
    @(negedge clk);
    rstN     = 1'b1;
    reqValid = 8'h12;
    @(negedge clk);
    #1;
    n_total++;
    if (p_sel !== 3'd1 || p_ready !== 8'h02) begin
      $display("FAIL arst_ptr0: got sel=%0d rdy=%h, expected sel=1 rdy=02", p_sel, p_ready);
    end else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rstN     = 1'b1;
    reqValid = 8'h00;
    reqLast  = 8'h00;
    outReady = 1'b0;
    #2;
    test_reset();
    test_beat_rotation();
    test_packet_hold();
    test_backpressure();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
